data_ram_arbiter: RTL and testbench

Two-requester arbiter that shares the data port (port 1) of the 128x16 dual-port program/data RAM between the processor's load/store path (requester 0) and a host loader/debug master (requester 1). It grants one access per cycle, drives the RAM's read/write enables, address and write data, and routes the one-cycle-latency read data back to the requester that issued the read. Requester 0 has reset priority. Sustained contention is bounded by a burst limit with round-robin hand-off.

---
 rtl/data_ram_arbiter.sv | 102 ++++++++++
 tb/tb_data_ram_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter for the data port of the shared 128x16 program/data RAM.
// Requester 0 is the processor load/store path, requester 1 the host loader/debug
// master. One access is granted per cycle. Sustained contention is bounded by a
// burst limit that hands ownership to the waiting side. Read data comes back one
// cycle after the grant and is routed to whichever requester issued the read.
module data_ram_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             rd_pend;
  logic             rd_tag;

  logic             burst_done;
  logic             gnt_any;
  logic             gnt_sel;   // 0 = requester 0 wins, 1 = requester 1 wins
  logic             gnt_we;

  // Grant decision and RAM port drive; everything is zero when nothing is granted.
  always_comb begin
    burst_done   = (cnt >= CNT_MAX);
    gnt_any      = ~reset & (m0_req | m1_req);
    gnt_sel      = 1'b0;
    if (m0_req && m1_req) begin
      // Owner keeps the port until its burst is used up, then the waiter takes it.
      gnt_sel = burst_done ? ~owner : owner;
    end else if (m1_req) begin
      gnt_sel = 1'b1;
    end
    m0_gnt       = gnt_any & ~gnt_sel;
    m1_gnt       = gnt_any &  gnt_sel;
    gnt_we       = gnt_sel ? m1_we : m0_we;
    ram_write_en = gnt_any &  gnt_we;
    ram_read_en  = gnt_any & ~gnt_we;
    ram_addr     = '0;
    ram_din      = '0;
    if (gnt_any) begin
      ram_addr = gnt_sel ? m1_addr  : m0_addr;
      ram_din  = gnt_sel ? m1_wdata : m0_wdata;
    end
  end

  // Ownership / burst count and the one-deep read-return tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= ram_read_en;
      if (ram_read_en) begin
        rd_tag <= gnt_sel;
      end
      if (!gnt_any) begin
        cnt <= '0;
      end else if (gnt_sel == owner) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        owner <= gnt_sel;
        cnt   <= CNT_ONE;
      end
    end
  end

  assign m0_rvalid = rd_pend & ~rd_tag;
  assign m1_rvalid = rd_pend &  rd_tag;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a small synchronous-read RAM model
// attached to the RAM port. Inputs change 2 time units after each rising edge;
// outputs are checked 1 time unit later, well before the next edge.
module tb_data_ram_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_read_en, ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM port 1 model: synchronous write, synchronous read (old data on same-cycle collision).
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, {m0_gnt, m1_gnt}, 2'b00);
    chk({tag, "_en"},  {ram_read_en, ram_write_en}, 2'b00);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_din"},  ram_din, 0);
    chk({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m0_req = 1'b1;  // request during reset must not be granted
    m0_addr = 7'd9;
    #3;
    chk_quiet("reset");
    tick();
    idle();
    reset = 1'b0;

    // Preload RAM through requester 1 writes.
    tick(); drive(0, 0, 0, 0, 1, 1, 7'd5, 16'h1234); #1;
    chk("pre_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("pre_we", {ram_write_en, ram_read_en}, 2'b10);
    chk("pre_addr", ram_addr, 5);
    chk("pre_din", ram_din, 16'h1234);
    tick(); drive(0, 0, 0, 0, 1, 1, 7'd1, 16'h1111);
    tick(); drive(0, 0, 0, 0, 1, 1, 7'd2, 16'h2222);
    tick(); drive(0, 0, 0, 0, 1, 1, 7'd3, 16'h3333);
    tick(); idle(); #1;
    chk("pre_norv", {m0_rvalid, m1_rvalid}, 2'b00);

    // Reset pulse returns ownership to requester 0.
    tick(); reset = 1'b1; #1; reset = 1'b0;

    // m0 read addr 5, m1 idle.
    tick(); drive(1, 0, 7'd5, 0, 0, 0, 0, 0); #1;
    chk("t1_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("t1_en", {ram_read_en, ram_write_en}, 2'b10);
    chk("t1_addr", ram_addr, 5);
    tick(); idle(); #1;
    chk("t1_rv", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t1_rdata", m0_rdata, 16'h1234);

    // m1 write then read of addr 10.
    tick(); drive(0, 0, 0, 0, 1, 1, 7'd10, 16'hBEEF); #1;
    chk("t2_wgnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("t2_wen", {ram_write_en, ram_read_en}, 2'b10);
    chk("t2_waddr", ram_addr, 10);
    chk("t2_wdin", ram_din, 16'hBEEF);
    tick(); drive(0, 0, 0, 0, 1, 0, 7'd10, 16'h0000); #1;
    chk("t2_ren", {ram_write_en, ram_read_en}, 2'b01);
    chk("t2_raddr", ram_addr, 10);
    chk("t2_wnorv", {m0_rvalid, m1_rvalid}, 2'b00);
    tick(); idle(); #1;
    chk("t2_rv", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("t2_rdata", m1_rdata, 16'hBEEF);

    // Continuous contention from reset: m0 x4, m1 x4, m0 x4.
    tick(); reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic e0, p0;
      tick(); drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0); #1;
      e0 = ((i / 4) % 2) == 0;
      chk($sformatf("t3_gnt%0d", i), {m0_gnt, m1_gnt}, {e0, ~e0});
      if (i > 0) begin
        p0 = (((i - 1) / 4) % 2) == 0;
        chk($sformatf("t3_rv%0d", i), {m0_rvalid, m1_rvalid}, {p0, ~p0});
        chk($sformatf("t3_rd%0d", i), m0_rdata, p0 ? 16'h1111 : 16'h2222);
      end
    end

    // Partial burst: m0 x2, m1 alone x1, then contention gives m1 three more.
    tick(); idle(); #1;
    chk("t4_idle_rv", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0); #1;
    chk("t4_a", {m0_gnt, m1_gnt}, 2'b10);
    tick(); #1;
    chk("t4_b", {m0_gnt, m1_gnt}, 2'b10);
    tick(); drive(0, 0, 0, 0, 1, 0, 7'd2, 0); #1;
    chk("t4_c", {m0_gnt, m1_gnt}, 2'b01);
    tick(); drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0); #1;
    chk("t4_d", {m0_gnt, m1_gnt}, 2'b01);
    tick(); #1;
    chk("t4_e", {m0_gnt, m1_gnt}, 2'b01);
    tick(); #1;
    chk("t4_f", {m0_gnt, m1_gnt}, 2'b01);
    tick(); #1;
    chk("t4_g", {m0_gnt, m1_gnt}, 2'b10);
    tick(); idle();

    // Alternating reads without contention.
    tick(); drive(1, 0, 7'd1, 0, 0, 0, 0, 0); #1;
    chk("t5_g0", {m0_gnt, m1_gnt}, 2'b10);
    tick(); drive(0, 0, 0, 0, 1, 0, 7'd2, 0); #1;
    chk("t5_g1", {m0_gnt, m1_gnt}, 2'b01);
    chk("t5_rv0", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t5_rd0", m0_rdata, 16'h1111);
    tick(); drive(1, 0, 7'd3, 0, 0, 0, 0, 0); #1;
    chk("t5_g2", {m0_gnt, m1_gnt}, 2'b10);
    chk("t5_rv1", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("t5_rd1", m1_rdata, 16'h2222);
    tick(); idle(); #1;
    chk("t5_rv2", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t5_rd2", m0_rdata, 16'h3333);
    tick(); #1;
    chk("t5_none", {m0_rvalid, m1_rvalid}, 2'b00);

    // Reset with a read in flight kills the response.
    tick(); drive(1, 0, 7'd5, 0, 0, 0, 0, 0); #1;
    chk("t6_gnt", {m0_gnt, m1_gnt}, 2'b10);
    tick(); idle(); reset = 1'b1; #1;
    chk_quiet("t6_rst");
    tick(); #1;
    chk("t6_rv_hold", {m0_rvalid, m1_rvalid}, 2'b00);
    reset = 1'b0;
    tick(); #1;
    chk("t6_rv_after", {m0_rvalid, m1_rvalid}, 2'b00);
    tick(); drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0); #1;
    chk("t6_first", {m0_gnt, m1_gnt}, 2'b10);
    tick(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
